// File: rtl/adc_model_pkg.sv
// Shared types and helpers for the multi-channel ADC behavioural model.
// Holds the sequencer state encoding, source-select codes, the SEU stretch
// length and the 2-of-3 voting helpers used on every control triple.
package adc_model_pkg;

  typedef enum logic [2:0] {
    ST_PD      = 3'd0,
    ST_CAL_RST = 3'd1,
    ST_CAL_RUN = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] MODE_INPUT     = 2'b00;
  localparam logic [1:0] MODE_RAMP      = 2'b01;
  localparam logic [1:0] MODE_PATTERN   = 2'b10;
  localparam logic [1:0] MODE_ALT_INPUT = 2'b11;  // decodes as MODE_INPUT

  localparam logic [2:0] SEU_STRETCH = 3'd4;

  function automatic logic tmr_vote(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic tmr_disagree(input logic a, input logic b, input logic c);
    return !((a == b) && (b == c));
  endfunction

endpackage

// File: rtl/adc_model_chan.sv
// One ADC channel: source mux, ramp generator, LAT-deep pipeline, output format, OVF.
// Latency: a source value captured at edge k reaches d after edge k+LAT.
// Backpressure: none; the stream free-runs while shift is high.
// Ports: clk/rst_n; shift (pipeline advances), active (outputs enabled),
//        df_fmt (latched format, 1 = two's complement), mode, sample -> d, ovf.
module adc_model_chan
  import adc_model_pkg::*;
#(
  parameter int W   = 12,
  parameter int LAT = 12,
  parameter int CH  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift,
  input  logic         active,
  input  logic         df_fmt,
  input  logic [1:0]   mode,
  input  logic [W-1:0] sample,
  output logic [W-1:0] d,
  output logic         ovf
);

  logic [W-1:0] pipe [LAT];
  logic [W-1:0] ramp;
  logic [W-1:0] pattern;
  logic [W-1:0] src;
  logic [W-1:0] last;

  // Alternating 0101... word with bit 0 set.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < W; i += 2) pattern[i] = 1'b1;
  end

  always_comb begin
    src = sample;
    case (mode)
      MODE_RAMP:    src = ramp;
      MODE_PATTERN: src = pattern;
      default:      src = sample;
    endcase
  end

  assign last = pipe[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      d   <= '0;
      ovf <= 1'b0;
    end else begin
      // Ramp parks at the channel index until the pipeline starts moving, so
      // the first captured ramp word of a run is CH.
      ramp <= shift ? ramp + W'(1) : W'(CH);
      if (shift) begin
        pipe[0] <= src;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end else begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end
      // Two's complement view is offset binary with the MSB flipped; OVF
      // looks at the raw code.
      d   <= active ? {last[W-1] ^ df_fmt, last[W-2:0]} : '0;
      ovf <= active && ((last == '0) || (last == '1));
    end
  end

endmodule

// File: rtl/adc_model_mch.sv
// Multi-channel ADC model top: TMR voters, calibration/flush sequencer, df trap, SEU stretch.
// Latency: SAMPLE_IN to D is LAT cycles; state changes reach outputs one cycle later.
// Backpressure: none; DVALID marks valid words, there is no ready input.
// Ports: CLK/RST_N; OM_*/DF_*/CAL_* control triples; MODE; SAMPLE_IN (NCH*W)
//        -> D (NCH*W), DVALID, OVF (NCH), CAL_BUSY, DF_ERR, SEU.
module adc_model_mch
  import adc_model_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int W          = 12,
  parameter int LAT        = 12,
  parameter int CAL_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             OM_A,
  input  logic             OM_B,
  input  logic             OM_C,
  input  logic             DF_A,
  input  logic             DF_B,
  input  logic             DF_C,
  input  logic             CAL_A,
  input  logic             CAL_B,
  input  logic             CAL_C,
  input  logic [1:0]       MODE,
  input  logic [NCH*W-1:0] SAMPLE_IN,
  output logic [NCH*W-1:0] D,
  output logic             DVALID,
  output logic [NCH-1:0]   OVF,
  output logic             CAL_BUSY,
  output logic             DF_ERR,
  output logic             SEU
);

  localparam int CMAX = (CAL_CYCLES > LAT) ? CAL_CYCLES : LAT;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] CAL_LAST   = CW'(CAL_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          df_lat;
  logic          om, df, cal, split;
  logic [2:0]    seu_cnt, seu_nxt;
  logic          shift, active;

  assign om  = tmr_vote(OM_A, OM_B, OM_C);
  assign df  = tmr_vote(DF_A, DF_B, DF_C);
  assign cal = tmr_vote(CAL_A, CAL_B, CAL_C);
  assign split = tmr_disagree(OM_A, OM_B, OM_C) |
                 tmr_disagree(DF_A, DF_B, DF_C) |
                 tmr_disagree(CAL_A, CAL_B, CAL_C);

  assign seu_nxt = split ? SEU_STRETCH :
                   (seu_cnt != 3'd0) ? seu_cnt - 3'd1 : 3'd0;

  assign shift  = (state == ST_FLUSH) || (state == ST_ACTIVE);
  assign active = (state == ST_ACTIVE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_PD;
      cnt      <= '0;
      df_lat   <= 1'b0;
      seu_cnt  <= 3'd0;
      SEU      <= 1'b0;
      DVALID   <= 1'b0;
      CAL_BUSY <= 1'b0;
      DF_ERR   <= 1'b0;
    end else begin
      seu_cnt  <= seu_nxt;
      SEU      <= (seu_nxt != 3'd0);
      DVALID   <= (state == ST_ACTIVE);
      CAL_BUSY <= (state == ST_CAL_RUN) || (state == ST_FLUSH);
      DF_ERR   <= (state == ST_ERR);

      // Priority: power-down, then df trap, then calibration hold.
      if (!om) begin
        state <= ST_PD;
        cnt   <= '0;
      end else begin
        case (state)
          ST_PD: begin
            state  <= ST_CAL_RUN;
            cnt    <= '0;
            df_lat <= df;
          end
          ST_ERR: begin
            state <= ST_ERR;
          end
          default: begin
            if (df != df_lat) begin
              state <= ST_ERR;
            end else if (cal) begin
              state <= ST_CAL_RST;
            end else begin
              case (state)
                ST_CAL_RST: begin
                  state <= ST_CAL_RUN;
                  cnt   <= '0;
                end
                ST_CAL_RUN: begin
                  if (cnt == CAL_LAST) begin
                    state <= ST_FLUSH;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + CW'(1);
                  end
                end
                ST_FLUSH: begin
                  if (cnt == FLUSH_LAST) begin
                    state <= ST_ACTIVE;
                    cnt   <= '0;
                  end else begin
                    cnt <= cnt + CW'(1);
                  end
                end
                default: begin
                  state <= state;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    adc_model_chan #(
      .W   (W),
      .LAT (LAT),
      .CH  (c)
    ) u_chan (
      .clk    (CLK),
      .rst_n  (RST_N),
      .shift  (shift),
      .active (active),
      .df_fmt (df_lat),
      .mode   (MODE),
      .sample (SAMPLE_IN[c*W +: W]),
      .d      (D[c*W +: W]),
      .ovf    (OVF[c])
    );
  end

endmodule
